ysyx_25020047_ifu: RTL and testbench
====================================

# ysyx_25020047_ifu

Instruction fetch unit for the multi-cycle NPC core. It holds the architectural PC and fetches one instruction at a time from instruction memory over a valid/ready request/response channel. It presents the fetched instruction to decode, then waits for the writeback stage to return the next PC (`dnpc`) before starting the next fetch. It is the consumer end of the writeback unit's `dnpc` output and closes the fetch→execute→writeback loop.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded on reset.
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out 32: fetch address; equals `pc`.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_rsp_valid` in 1: response valid; single-cycle pulse, no backpressure.
- `imem_rsp_data` in 32: instruction word.
- `imem_rsp_err` in 1: access fault; qualified by `imem_rsp_valid`.
- `inst_valid` out 1: instruction available to decode.
- `inst_ready` in 1: decode accepts the instruction.
- `inst` out 32: registered instruction word.
- `pc` out 32: address of `inst`.
- `snpc` out 32: `pc` + 4.
- `wb_valid` in 1: writeback has produced the next PC.
- `wb_dnpc` in 32: next PC from writeback.
- `fetch_err` out 1: sticky fault flag.

## Operation
- States: IDLE, REQ, WAIT, ISSUE, EXEC, HALT.
- IDLE → REQ unconditionally. This is the first cycle after `rst` deasserts.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. On `imem_req_valid && imem_req_ready`, go to WAIT. Address is held stable until accepted.
- WAIT: on `imem_rsp_valid`:
  - If `imem_rsp_err`=0, capture `inst` ← `imem_rsp_data` and go to ISSUE.
  - If `imem_rsp_err`=1, set `fetch_err`=1 and go to HALT.
- ISSUE: `inst_valid`=1 and `inst` stays stable. On `inst_valid && inst_ready`, go to EXEC.
- EXEC: on `wb_valid`, load `pc` ← `wb_dnpc` and go to REQ.
- HALT: absorbing state. No requests, `inst_valid`=0. Left only by `rst`.
- Ignored inputs:
  - `imem_rsp_valid` outside WAIT is ignored; this includes a stale response after reset.
  - `wb_valid` outside EXEC is ignored; this includes `wb_valid` coincident with the ISSUE handshake.
- Arithmetic: `snpc` = `pc` + 32'd4, modulo 2^32 (0xFFFF_FFFC → 0x0000_0000). `wb_dnpc` is taken verbatim.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `inst`=0, `imem_req_valid`=0, `inst_valid`=0, `fetch_err`=0.
- `imem_req_valid` and `inst_valid` are decodes of the registered state. They never combinationally depend on `ready` inputs.
- Minimum loop, with `imem_req_ready`=1, response one cycle after request, and `inst_ready`=1:
  - Cycle 0: REQ.
  - Cycle 1: WAIT, response arrives.
  - Cycle 2: ISSUE.
  - Cycle 3: EXEC.
  - Next REQ is the cycle after `wb_valid`.
- First `imem_req_valid` is 2 cycles after the last `rst`-high edge (IDLE, then REQ).
- `rst` asserted mid-operation, in any state, returns to reset values at the next edge. Any outstanding memory response is discarded.

## Configuration
- `YSYX_25020047_IFU_MISALIGN_CHECK_EN` defined:
  - In EXEC, `wb_valid` with `wb_dnpc[1:0]`≠0 sets `fetch_err`=1 and moves to HALT; `pc` is not updated.
  - `RESET_PC` misalignment is not checked.
- Not defined: `wb_dnpc` is loaded unconditionally and `fetch_err` is set only by `imem_rsp_err`.

## Structure
- Shared package `ysyx_25020047_pkg` holds:
  - State encoding localparams: IDLE=0, REQ=1, WAIT=2, ISSUE=3, EXEC=4, HALT=5; 3-bit width.
  - Default reset PC constant 32'h8000_0000, shared with the writeback and memory model.
- No sub-module is warranted. Single module: one state register, `pc`/`inst`/`fetch_err` registers, and combinational output decode.

## Test plan
- Reset then free-run with `imem_req_ready`=1, response next cycle, `inst_ready`=1, `wb_dnpc`=`snpc`:
  - Request addresses 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - `snpc` is always `pc`+4.
- Backpressure, `imem_req_ready` low 3 cycles then high: `imem_req_addr` stays stable and exactly one request fires. Then `inst_ready` low 4 cycles: `inst` and `pc` stay stable, with one handshake.
- Jump, `wb_dnpc`=0x8000_0100: next `imem_req_addr`=0x8000_0100.
- Wrap: `wb_dnpc`=0xFFFF_FFFC gives `snpc`=0x0000_0000.
- Ignored inputs: stray `imem_rsp_valid` in REQ and `wb_valid` in ISSUE must cause no state or `pc` change.
- Fault cases:
  - `imem_rsp_err`=1 in WAIT: `fetch_err`=1 and no further requests.
  - With the macro defined, `wb_dnpc`=0x8000_0002: `fetch_err`=1 and `pc` is unchanged.
  - Then `rst`: `fetch_err`=0 and a request to 0x8000_0000 two cycles later.

Source files
------------

// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the NPC front end: IFU state encoding and reset PC.
package ysyx_25020047_pkg;

    localparam int unsigned IFU_STATE_W = 3;

    localparam logic [IFU_STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [IFU_STATE_W-1:0] S_REQ   = 3'd1;
    localparam logic [IFU_STATE_W-1:0] S_WAIT  = 3'd2;
    localparam logic [IFU_STATE_W-1:0] S_ISSUE = 3'd3;
    localparam logic [IFU_STATE_W-1:0] S_EXEC  = 3'd4;
    localparam logic [IFU_STATE_W-1:0] S_HALT  = 3'd5;

    typedef enum logic [IFU_STATE_W-1:0] {
        IFU_IDLE  = S_IDLE,
        IFU_REQ   = S_REQ,
        IFU_WAIT  = S_WAIT,
        IFU_ISSUE = S_ISSUE,
        IFU_EXEC  = S_EXEC,
        IFU_HALT  = S_HALT
    } ifu_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: one fetch in flight, waits for writeback dnpc.
// Optional macro YSYX_25020047_IFU_MISALIGN_CHECK_EN traps misaligned dnpc.
module ysyx_25020047_ifu
    import ysyx_25020047_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] snpc,
    input  logic        wb_valid,
    input  logic [31:0] wb_dnpc,
    output logic        fetch_err
);

    ifu_state_t  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_err;
    logic        w_dnpc_bad;

`ifdef YSYX_25020047_IFU_MISALIGN_CHECK_EN
    assign w_dnpc_bad = (wb_dnpc[1:0] != 2'b00);
`else
    assign w_dnpc_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IFU_IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IFU_IDLE: r_state <= IFU_REQ;
                IFU_REQ: begin
                    if (imem_req_ready) r_state <= IFU_WAIT;
                end
                IFU_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            r_err   <= 1'b1;
                            r_state <= IFU_HALT;
                        end else begin
                            r_inst  <= imem_rsp_data;
                            r_state <= IFU_ISSUE;
                        end
                    end
                end
                IFU_ISSUE: begin
                    if (inst_ready) r_state <= IFU_EXEC;
                end
                IFU_EXEC: begin
                    // a trapped dnpc leaves pc pointing at the faulting fetch
                    if (wb_valid) begin
                        if (w_dnpc_bad) begin
                            r_err   <= 1'b1;
                            r_state <= IFU_HALT;
                        end else begin
                            r_pc    <= wb_dnpc;
                            r_state <= IFU_REQ;
                        end
                    end
                end
                IFU_HALT: r_state <= IFU_HALT;
                default:  r_state <= IFU_HALT;
            endcase
        end
    end

    assign imem_req_valid = (r_state == IFU_REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == IFU_ISSUE);
    assign inst           = r_inst;
    assign pc             = r_pc;
    assign snpc           = seq_pc(r_pc);
    assign fetch_err      = r_err;

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Self-checking bench for ysyx_25020047_ifu: vector table, corner sequences,
// and randomized loops against a transaction-level PC model.
module tb_ysyx_25020047_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic        wb_valid;
    logic [31:0] wb_dnpc;
    logic        fetch_err;

    int nvec = 0;
    int nerr = 0;

    ysyx_25020047_ifu dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .pc            (pc),
        .snpc          (snpc),
        .wb_valid      (wb_valid),
        .wb_dnpc       (wb_dnpc),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reset, verify reset values, release with a stale response, expect REQ.
    task automatic reset_recover;
        rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0bad_0bad;
        tick;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst, 0);
        check("rst_fetch_err", fetch_err, 0);
        rst = 1'b0;
        check("idle_no_req", imem_req_valid, 0);
        tick;
        imem_rsp_valid = 1'b0;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, 32'h8000_0000);
    endtask

    // One fetch loop starting in REQ; ends right after wb_valid is consumed.
    task automatic fetch_one(input logic [31:0] exp_pc, input logic [31:0] data,
                             input logic [31:0] dnpc, input int req_stall,
                             input int rsp_gap, input int inst_stall,
                             input int wb_gap, input bit stray);
        check("req_valid", imem_req_valid, 1);
        check("req_addr", imem_req_addr, exp_pc);
        for (int k = 0; k < req_stall; k++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = stray;
            imem_rsp_err   = stray;
            imem_rsp_data  = 32'hdead_beef;
            tick;
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            check("req_hold_valid", imem_req_valid, 1);
            check("req_hold_addr", imem_req_addr, exp_pc);
            check("req_hold_err", fetch_err, 0);
        end
        imem_req_ready = 1'b1;
        tick;
        imem_req_ready = 1'b0;
        for (int k = 0; k < rsp_gap; k++) begin
            check("wait_no_req", imem_req_valid, 0);
            tick;
        end
        check("single_req", imem_req_valid, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick;
        imem_rsp_valid = 1'b0;
        check("inst_valid", inst_valid, 1);
        check("inst", inst, data);
        check("pc", pc, exp_pc);
        check("snpc", snpc, exp_pc + 32'd4);
        for (int k = 0; k < inst_stall; k++) begin
            inst_ready = 1'b0;
            wb_valid   = stray;
            wb_dnpc    = 32'h1234_5670;
            tick;
            wb_valid = 1'b0;
            check("issue_hold_valid", inst_valid, 1);
            check("issue_hold_inst", inst, data);
            check("issue_hold_pc", pc, exp_pc);
        end
        inst_ready = 1'b1;
        wb_valid   = stray;
        wb_dnpc    = 32'h1234_5670;
        tick;
        inst_ready = 1'b0;
        wb_valid   = 1'b0;
        check("one_handshake", inst_valid, 0);
        check("exec_pc", pc, exp_pc);
        for (int k = 0; k < wb_gap; k++) begin
            tick;
            check("exec_no_req", imem_req_valid, 0);
        end
        wb_valid = 1'b1;
        wb_dnpc  = dnpc;
        tick;
        wb_valid = 1'b0;
    endtask

    // Fetch from REQ whose response faults; the unit must then stay silent.
    task automatic fetch_fault(input logic [31:0] exp_pc);
        check("flt_req_addr", imem_req_addr, exp_pc);
        imem_req_ready = 1'b1;
        tick;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        tick;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        check("flt_err", fetch_err, 1);
        check("flt_no_inst", inst_valid, 0);
        for (int k = 0; k < 4; k++) begin
            imem_rsp_valid = 1'(k & 1);
            tick;
            check("halt_no_req", imem_req_valid, 0);
            check("halt_err", fetch_err, 1);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] data;
        logic [31:0] dnpc;
        logic [31:0] exp_pc;
        logic [31:0] exp_snpc;
    } vec_t;

    vec_t tbl[5];
    logic [31:0] model_pc;
    logic [31:0] nxt;

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        wb_valid       = 1'b0;
        wb_dnpc        = '0;

        tbl[0] = '{32'h0000_0013, 32'h8000_0004, 32'h8000_0000, 32'h8000_0004};
        tbl[1] = '{32'h0010_0093, 32'h8000_0008, 32'h8000_0004, 32'h8000_0008};
        tbl[2] = '{32'h0000_006f, 32'h8000_0100, 32'h8000_0008, 32'h8000_000c};
        tbl[3] = '{32'h00a0_0113, 32'hffff_fffc, 32'h8000_0100, 32'h8000_0104};
        tbl[4] = '{32'hffc1_0113, 32'h8000_0200, 32'hffff_fffc, 32'h0000_0000};

        @(negedge clk);
        tick;
        reset_recover();

        for (int i = 0; i < 5; i++) begin
            check("tbl_pc", imem_req_addr, tbl[i].exp_pc);
            check("tbl_snpc", snpc, tbl[i].exp_snpc);
            fetch_one(tbl[i].exp_pc, tbl[i].data, tbl[i].dnpc, 0, 0, 0, 0, 0);
        end

        fetch_one(32'h8000_0200, 32'h1111_2222, 32'h8000_0204, 3, 2, 4, 2, 1);

        fetch_one(32'h8000_0204, 32'h3333_4444, 32'h8000_0002, 0, 0, 0, 1, 0);
`ifdef YSYX_25020047_IFU_MISALIGN_CHECK_EN
        check("mis_err", fetch_err, 1);
        check("mis_pc", pc, 32'h8000_0204);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("mis_no_req", imem_req_valid, 0);
        end
`else
        check("mis_no_err", fetch_err, 0);
        check("mis_req", imem_req_addr, 32'h8000_0002);
        fetch_fault(32'h8000_0002);
`endif
        reset_recover();
        fetch_fault(32'h8000_0000);
        reset_recover();

        imem_req_ready = 1'b1;
        tick;
        imem_req_ready = 1'b0;
        reset_recover();

        model_pc = 32'h8000_0000;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       nxt = model_pc + 32'd4;
                1:       nxt = {$urandom(), 2'b00} >> 0 & 32'hffff_fffc;
                2:       nxt = 32'hffff_fffc;
                default: nxt = model_pc - 32'd8;
            endcase
            fetch_one(model_pc, $urandom(), nxt, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            model_pc = nxt;
        end
        check("rnd_final_req", imem_req_valid, 1);
        check("rnd_final_addr", imem_req_addr, model_pc);
        check("rnd_final_err", fetch_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
